// File: rtl/mdu_e.sv
// E-stage multi-cycle multiply/divide unit holding architectural HI/LO.
// Optional madd/maddu accumulate is enabled by defining MDU_MADD_EN.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [15:0] MC = 16'(MULT_CYCLES);
  localparam logic [15:0] DC = 16'(DIV_CYCLES);

  logic [15:0] cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        wr_pend;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] ub_nz;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        sgn_div;
  logic        neg_q;
  logic        neg_r;

  logic        launch;
  logic [63:0] nxt_res;
  logic        nxt_pend;
  logic [15:0] nxt_cnt;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // signed divide runs on magnitudes, so 0x80000000 / -1 wraps cleanly
  assign sgn_div = (mdop == 4'd3);
  assign ua      = (sgn_div && a[31]) ? -a : a;
  assign ub      = (sgn_div && b[31]) ? -b : b;
  assign ub_nz   = (ub == 32'd0) ? 32'd1 : ub;
  assign uq      = ua / ub_nz;
  assign ur      = ua % ub_nz;
  assign neg_q   = sgn_div & (a[31] ^ b[31]);
  assign neg_r   = sgn_div & a[31];

`ifdef MDU_MADD_EN
  logic [63:0] acc_s;
  logic [63:0] acc_u;
  assign acc_s = {hi, lo} + prod_s;
  assign acc_u = {hi, lo} + prod_u;
`endif

  always_comb begin
    launch   = 1'b1;
    nxt_res  = prod_s;
    nxt_pend = 1'b1;
    nxt_cnt  = MC;
    case (mdop)
      4'd1: nxt_res = prod_s;
      4'd2: nxt_res = prod_u;
      4'd3, 4'd4: begin
        nxt_res  = {(neg_r ? -ur : ur), (neg_q ? -uq : uq)};
        nxt_pend = (b != 32'd0);
        nxt_cnt  = DC;
      end
`ifdef MDU_MADD_EN
      4'd7: nxt_res = acc_s;
      4'd8: nxt_res = acc_u;
`endif
      default: launch = 1'b0;
    endcase
    launch = launch & start;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      wr_pend <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
      if (cnt == 16'd1 && wr_pend) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (launch) begin
      cnt              <= nxt_cnt;
      {res_hi, res_lo} <= nxt_res;
      wr_pend          <= nxt_pend;
    end else if (mdop == 4'd5) begin
      hi <= a;
    end else if (mdop == 4'd6) begin
      lo <= a;
    end
  end

  assign busy  = (cnt != 16'd0);
  assign stall = md_use & (start | busy);

endmodule

// File: tb/tb_mdu_e.sv
// Randomized + directed bench for mdu_e against a cycle-level arithmetic model.
// Define MDU_MADD_EN to also check madd/maddu.
module tb_mdu_e;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdop = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        md_use = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_res = '0;
  logic        m_pend = 1'b0;
  int          m_left = 0;

  logic seen_busy;
  logic seen_stall;

  always #5 clk = ~clk;

  mdu_e dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mdop(mdop),
    .a(a),
    .b(b),
    .md_use(md_use),
    .busy(busy),
    .stall(stall),
    .hi(hi),
    .lo(lo)
  );

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_md(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
`else
    return op inside {4'd1, 4'd2, 4'd3, 4'd4};
`endif
  endfunction

  function automatic logic [63:0] ref_calc(input logic [3:0] op,
                                           input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [63:0] acc);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    res = '0;
    case (op)
      4'd1: res = sx * sy;
      4'd2: res = ux * uy;
      4'd3: begin
        q = sx / sy;
        r = sx % sy;
        res = {r[31:0], q[31:0]};
      end
      4'd4: begin
        uq = ux / uy;
        ur = ux % uy;
        res = {ur[31:0], uq[31:0]};
      end
      4'd7: res = acc + 64'(sx * sy);
      4'd8: res = acc + 64'(ux * uy);
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic model_edge();
    bit dv;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pend) {m_hi, m_lo} = m_res;
    end else if (start && is_md(mdop)) begin
      dv     = (mdop == 4'd3 || mdop == 4'd4);
      m_pend = !(dv && b == 32'd0);
      if (m_pend) m_res = ref_calc(mdop, a, b, {m_hi, m_lo});
      m_left = dv ? 10 : 5;
    end else if (mdop == 4'd5) begin
      m_hi = a;
    end else if (mdop == 4'd6) begin
      m_lo = a;
    end
  endtask

  task automatic model_reset();
    m_hi   = '0;
    m_lo   = '0;
    m_res  = '0;
    m_pend = 1'b0;
    m_left = 0;
  endtask

  task automatic cyc(input logic s, input logic [3:0] op,
                     input logic [31:0] av, input logic [31:0] bv,
                     input logic mu);
    start  = s;
    mdop   = op;
    a      = av;
    b      = bv;
    md_use = mu;
    @(negedge clk);
    seen_busy  = busy;
    seen_stall = stall;
    expect_eq("busy", {31'd0, busy}, {31'd0, m_left != 0});
    expect_eq("stall", {31'd0, stall}, {31'd0, mu & (s | (m_left != 0))});
    expect_eq("hi", hi, m_hi);
    expect_eq("lo", lo, m_lo);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic mu, output int nb);
    nb = 0;
    repeat (n) begin
      cyc(1'b0, 4'd0, '0, '0, mu);
      nb += int'(seen_busy);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb;
    logic [3:0] op;
    logic s;

    repeat (2) @(posedge clk);
    #1;
    expect_eq("rst_busy", {31'd0, busy}, 32'd0);
    expect_eq("rst_hi", hi, 32'd0);
    expect_eq("rst_lo", lo, 32'd0);
    md_use = 1'b1;
    start  = 1'b1;
    #1;
    expect_eq("rst_stall_start", {31'd0, stall}, 32'd1);
    start = 1'b0;
    #1;
    expect_eq("rst_stall_idle", {31'd0, stall}, 32'd0);
    md_use = 1'b0;
    reset  = 1'b1;

    cyc(1'b1, 4'd1, -32'sd3, 32'd5, 1'b0);
    idle(6, 1'b0, nb);
    expect_eq("mult_busy_cycles", nb, 32'd5);
    expect_eq("mult_hi", hi, 32'hFFFF_FFFF);
    expect_eq("mult_lo", lo, 32'hFFFF_FFF1);

    cyc(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(6, 1'b0, nb);
    expect_eq("multu_hi", hi, 32'h0000_0001);
    expect_eq("multu_lo", lo, 32'hFFFF_FFFE);

    cyc(1'b1, 4'd3, 32'd7, -32'sd2, 1'b0);
    idle(11, 1'b0, nb);
    expect_eq("div_busy_cycles", nb, 32'd10);
    expect_eq("div_lo", lo, 32'hFFFF_FFFD);
    expect_eq("div_hi", hi, 32'h0000_0001);

    cyc(1'b1, 4'd4, 32'd7, 32'd0, 1'b0);
    idle(11, 1'b0, nb);
    expect_eq("divz_busy_cycles", nb, 32'd10);
    expect_eq("divz_hi", hi, 32'h0000_0001);
    expect_eq("divz_lo", lo, 32'hFFFF_FFFD);

    cyc(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(11, 1'b0, nb);
    expect_eq("divovf_lo", lo, 32'h8000_0000);
    expect_eq("divovf_hi", hi, 32'h0000_0000);

    cyc(1'b1, 4'd4, 32'd100, 32'd7, 1'b1);
    nb = 0;
    repeat (10) begin
      cyc(1'b0, 4'd6, 32'hDEAD_BEEF, '0, 1'b1);
      nb += int'(seen_stall);
    end
    expect_eq("busy_stall_cycles", nb, 32'd10);
    cyc(1'b0, 4'd0, '0, '0, 1'b1);
    expect_eq("stall_after_busy", {31'd0, seen_stall}, 32'd0);
    expect_eq("divu_lo", lo, 32'd14);
    expect_eq("divu_hi", hi, 32'd2);

    cyc(1'b1, 4'd1, 32'd3, 32'd3, 1'b0);
    idle(2, 1'b0, nb);
    #1 reset = 1'b0;
    #1;
    expect_eq("abort_busy", {31'd0, busy}, 32'd0);
    expect_eq("abort_hi", hi, 32'd0);
    expect_eq("abort_lo", lo, 32'd0);
    model_reset();
    #1 reset = 1'b1;
    idle(8, 1'b0, nb);
    expect_eq("abort_busy_after", nb, 32'd0);
    expect_eq("abort_no_commit", lo, 32'd0);

    cyc(1'b0, 4'd5, 32'd0, '0, 1'b0);
    cyc(1'b0, 4'd6, 32'hFFFF_FFFF, '0, 1'b0);
    cyc(1'b1, 4'd8, 32'd1, 32'd1, 1'b0);
    idle(6, 1'b0, nb);
`ifdef MDU_MADD_EN
    expect_eq("maddu_busy_cycles", nb, 32'd5);
    expect_eq("maddu_hi", hi, 32'd1);
    expect_eq("maddu_lo", lo, 32'd0);
`else
    expect_eq("maddu_off_busy", nb, 32'd0);
    expect_eq("maddu_off_hi", hi, 32'd0);
    expect_eq("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 10));
      s  = (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8}) &&
           ($urandom % 4 != 0);
      cyc(s, op, pick(), pick(), 1'($urandom));
    end
    idle(12, 1'b0, nb);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
